// File: rtl/minimap_drawer.sv
// minimap_drawer: walks the 40x30 level grid and plots each cell as a 4x4 block with a player marker
module minimap_drawer (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    input  logic [5:0] player_x,
    input  logic [4:0] player_y,
    output logic [5:0] grid_x,
    output logic [4:0] grid_y,
    input  logic [2:0] grid_out,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
);
    typedef enum logic [2:0] {IDLE, LATCH, READ, FETCH, PLOT, NEXT, DONE} state_t;
    state_t     state;
    logic [5:0] cx;
    logic [4:0] cy;
    logic [3:0] pix;
    logic [2:0] cell_colour;
    logic [5:0] px_l;
    logic [4:0] py_l;
    assign grid_x = cx;
    assign grid_y = cy;
    assign vga_x  = {cx, pix[1:0]};
    assign vga_y  = {cy, pix[3:2]};
    assign colour = cell_colour;
    // Scan sequencer: one READ/FETCH per cell, sixteen PLOT cycles, then advance row-major
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            pix         <= '0;
            cell_colour <= '0;
            px_l        <= '0;
            py_l        <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            plot        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    px_l  <= player_x;
                    py_l  <= player_y;
                    cx    <= '0;
                    cy    <= '0;
                    pix   <= '0;
                    state <= READ;
                end
                READ: state <= FETCH;
                FETCH: begin
                    cell_colour <= (cx == px_l && cy == py_l) ? 3'b010 : grid_out;
                    plot        <= 1'b1;
                    state       <= PLOT;
                end
                PLOT: begin
                    pix <= pix + 4'd1;
                    if (pix == 4'd15) begin
                        plot  <= 1'b0;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (cx == 6'd39 && cy == 5'd29) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cx == 6'd39) begin
                        cx    <= '0;
                        cy    <= cy + 5'd1;
                        state <= READ;
                    end else begin
                        cx    <= cx + 6'd1;
                        state <= READ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    plot  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_minimap_drawer.sv
// tb_minimap_drawer: scoreboard bench for minimap_drawer with a 1-cycle-latency grid memory model
module tb_minimap_drawer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] player_x = '0;
    logic [4:0] player_y = '0;
    logic [2:0] grid_out = '0;
    logic       done, busy, plot;
    logic [5:0] grid_x;
    logic [4:0] grid_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    px_t  q[$];
    px_t  e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   plot_cnt = 0;
    int   last_x = 0;
    int   last_y = 0;
    int   t0 = 0;
    bit   mode = 1'b0;
    logic [6:0] sum;

    minimap_drawer dut (
        .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
        .player_x(player_x), .player_y(player_y), .grid_x(grid_x), .grid_y(grid_y),
        .grid_out(grid_out), .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Grid memory: uniform colour 1, or (x+y)%8, one cycle after the address
    assign sum = {1'b0, grid_x} + {2'b0, grid_y};
    always @(posedge clock) grid_out <= mode ? sum[2:0] : 3'd1;

    // Plot monitor: every plotted pixel must match the head of the scoreboard
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (plot) begin
            plot_cnt++;
            last_x = int'(vga_x);
            last_y = int'(vga_y);
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot: got (%0d,%0d) colour %0d, required no plot", vga_x, vga_y, colour);
            end else begin
                e = q.pop_front();
                if ({vga_x, vga_y, colour} !== {e.x, e.y, e.c}) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                             vga_x, vga_y, colour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic push_frame(input int px, input int py);
        px_t p;
        int  c;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) begin
                c = (x == px && y == py) ? 2 : (mode ? (x + y) % 8 : 1);
                for (int k = 0; k < 16; k++) begin
                    p.x = 8'(x * 4 + k % 4);
                    p.y = 7'(y * 4 + k / 4);
                    p.c = 3'(c);
                    q.push_back(p);
                end
            end
    endtask

    task automatic begin_frame(input int px, input int py);
        player_x = 6'(px);
        player_y = 5'(py);
        push_frame(px, py);
        plot_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({done, busy, plot, vga_x, vga_y, colour, grid_x, grid_y} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, required all 0",
                         done, busy, plot, vga_x, vga_y, colour);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || plot_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b plots=%0d, required busy=0 plots=0", busy, plot_cnt);
        end
    endtask

    task automatic test_uniform;
        int  dc0, lat;
        bit  ok;
        mode = 1'b0;
        dc0 = done_cnt;
        begin_frame(63, 31);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 30000 && !ok; i++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                lat = cyc - t0;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL uniform_timeout: got no done, required done");
        end
        checks++;
        if (lat != 22801) begin
            errors++;
            $display("FAIL uniform_latency: got %0d, required 22801", lat);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (done_cnt != dc0 + 1) begin
            errors++;
            $display("FAIL uniform_done_count: got %0d, required %0d", done_cnt - dc0, 1);
        end
        checks++;
        if (plot_cnt != 19200 || q.size() != 0) begin
            errors++;
            $display("FAIL uniform_plots: got %0d plots, %0d pending, required 19200, 0", plot_cnt, q.size());
        end
        checks++;
        if (last_x != 159 || last_y != 119) begin
            errors++;
            $display("FAIL uniform_last: got (%0d,%0d), required (159,119)", last_x, last_y);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL uniform_busy_after: got %b, required 0", busy);
        end
    endtask

    task automatic test_pattern_row_wrap;
        int  dc0, lat;
        bit  ok, seen, wrapped;
        mode = 1'b1;
        dc0 = done_cnt;
        begin_frame(5, 3);
        ok = 1'b0;
        seen = 1'b0;
        wrapped = 1'b0;
        lat = 0;
        for (int i = 0; i < 30000 && !ok; i++) begin
            @(negedge clock);
            if (plot) begin
                if (seen && !wrapped) begin
                    wrapped = 1'b1;
                    checks++;
                    if (vga_x !== 8'd0 || vga_y !== 7'd4) begin
                        errors++;
                        $display("FAIL row_wrap: got (%0d,%0d), required (0,4)", vga_x, vga_y);
                    end
                end
                if (vga_x == 8'd159 && vga_y == 7'd3) seen = 1'b1;
            end
            if (done) begin
                ok = 1'b1;
                lat = cyc - t0;
            end
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL row_wrap_seen: got no transition after (159,3), required one");
        end
        checks++;
        if (!ok || lat != 22801) begin
            errors++;
            $display("FAIL pattern_latency: got %0d (done=%b), required 22801", lat, ok);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (plot_cnt != 19200 || q.size() != 0 || done_cnt != dc0 + 1) begin
            errors++;
            $display("FAIL pattern_frame: got %0d plots, %0d pending, %0d dones, required 19200, 0, 1",
                     plot_cnt, q.size(), done_cnt - dc0);
        end
    endtask

    task automatic test_reset_mid_and_busy_start;
        int  dc0, pc0, lat;
        bit  ok;
        mode = 1'b1;
        begin_frame(5, 3);
        repeat (10000) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got plot=%b busy=%b, required 0 0", plot, busy);
        end
        q.delete();
        dc0 = done_cnt;
        pc0 = plot_cnt;
        repeat (100) @(negedge clock);
        checks++;
        if (done_cnt != dc0 || plot_cnt != pc0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d dones %0d plots, required 0 0", done_cnt - dc0, plot_cnt - pc0);
        end
        begin_frame(7, 2);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 30000 && !ok; i++) begin
            @(negedge clock);
            if (i == 5000) begin
                start = 1'b1;
                player_x = 6'd10;
                player_y = 5'd20;
            end
            if (i == 5001) start = 1'b0;
            if (done) begin
                ok = 1'b1;
                lat = cyc - t0;
            end
        end
        checks++;
        if (!ok || lat != 22801) begin
            errors++;
            $display("FAIL busy_start_latency: got %0d (done=%b), required 22801", lat, ok);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (done_cnt != dc0 + 1 || plot_cnt != 19200 || q.size() != 0) begin
            errors++;
            $display("FAIL busy_start_frame: got %0d dones %0d plots %0d pending, required 1 19200 0",
                     done_cnt - dc0, plot_cnt, q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_pattern_row_wrap();
        test_reset_mid_and_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/minimap_drawer.md
# minimap_drawer

Downstream consumer of the level grid. Once the level loader has filled the 40x30 grid memory, this block walks every cell, reads its 3-bit value from the grid memory's read port, and plots it as a 4x4 pixel block on the 160x120 VGA adapter. The player's current cell is overlaid as a marker. Control uses the same start/done pulse handshake as the level loader, so the top-level controller can chain load → draw.

## Interface
Parameters: none. Grid is fixed at 40x30 cells, 4x4 pixels per cell, 160x120 pixels.

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock
- start  in  1  begin a full redraw; sampled only in IDLE
- done  out  1  one-cycle pulse when the last pixel has been plotted
- busy  out  1  high in every state except IDLE
- player_x  in  6  player cell column, 0..39; captured at draw start
- player_y  in  5  player cell row, 0..29; captured at draw start
- grid_x  out  6  grid memory read column
- grid_y  out  5  grid memory read row
- grid_out  in  3  grid memory read data; valid exactly 1 cycle after grid_x/grid_y are presented
- vga_x  out  8  pixel column = {grid_x, pix[1:0]}
- vga_y  out  7  pixel row = {grid_y, pix[3:2]}
- colour  out  3  pixel colour
- plot  out  1  VGA write enable

## Operation
- Registers:
  - state (3 b)
  - cell counters cx (6 b, 0..39) and cy (5 b, 0..29)
  - pixel counter pix (4 b)
  - cell_colour (3 b)
  - latched player position px_l / py_l
- grid_x = cx, grid_y = cy. vga_x, vga_y and colour are derived from these registers; there is no extra output pipeline.
- States:
  - IDLE: if start → LATCH, else stay.
  - LATCH: capture px_l, py_l; clear cx, cy, pix → READ.
  - READ: address (cx,cy) is on grid_x/grid_y; wait for memory latency → FETCH.
  - FETCH: load cell_colour:
    - 3'b010 if (cx,cy) == (px_l,py_l);
    - otherwise grid_out (value 0 = empty = black 3'b000, values 1..7 pass through as colour).
    - → PLOT.
  - PLOT: plot=1, colour=cell_colour; pix increments each cycle. When pix==15 → NEXT (pix wraps to 0).
  - NEXT:
    - if cx==39 and cy==29 → DONE;
    - else if cx==39: cx←0, cy←cy+1, → READ;
    - else: cx←cx+1, → READ.
  - DONE: done=1 → IDLE.
- Scan order is row-major, x fastest. Pixel order inside a cell is row-major: pix[1:0] is the column offset, pix[3:2] is the row offset.
- Player position outside range (x>39 or y>29): no marker is drawn; all cells show grid_out.
- start while busy: ignored. A start held high in DONE is not seen until IDLE, so a held start causes a back-to-back redraw.
- Changes to player_x/player_y mid-draw are ignored until the next LATCH.

## Timing
- Reset (reset==0 at an edge) forces, on that edge:
  - state=IDLE
  - cx=cy=pix=0
  - cell_colour=0
  - px_l=py_l=0
- Outputs after reset: done=0, busy=0, plot=0, grid_x=0, grid_y=0, vga_x=0, vga_y=0, colour=0.
- Reset mid-draw aborts immediately: plot is low from the next cycle and no done pulse is issued.
- Per cell: 19 cycles (READ 1, FETCH 1, PLOT 16, NEXT 1). Full frame: 1200 cells.
- Edge E0 samples start=1 in IDLE; then:
  - LATCH follows; READ of cell (0,0) is entered at E1.
  - DONE state is entered at E22801; done is high for exactly that one cycle.
  - IDLE is re-entered at E22802.
- plot is high for exactly 19200 cycles per frame, in 1200 bursts of 16 consecutive cycles.
- grid_out is sampled only in FETCH, one cycle after the address has been stable through READ.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1 → done=0, busy=0, plot=0, vga_x=0, vga_y=0, colour=0; nothing is drawn.
- Full frame, uniform grid: memory model returns 3'b001 for all cells, player=(63,31) (out of range) → 19200 plots, all colour 1; first plot at (0,0), last at (159,119); done pulses once, exactly 22801 edges after start was sampled.
- Pattern and latency: grid_out = (x+y)%8 with 1-cycle read latency; player=(5,3) → pixels x 20..23, y 12..15 are colour 3'b010; every other block shows (x+y)%8; each pixel is written exactly once.
- Row wrap: check the transition from cell (39,0) to (0,1) → last plot of cell (39,0) at (159,3); next plot at (0,4).
- Start while busy / player change: pulse start and change player_x at cycle 5000 → no restart, done count remains 1, marker stays at the original position.
- Reset mid-draw: assert reset=0 at cycle 10000 for 1 cycle → plot=0 and busy=0 from the next cycle, no done pulse; a new start then produces a full, correct frame.
